// File: rtl/boron_pkg.sv
// Shared constants and lane helper functions for the boron round permutation layer.
package boron_pkg;

    localparam int unsigned BORON_LANES      = 4;
    localparam int unsigned BORON_LANE_W     = 16;
    localparam int unsigned BORON_ROT_W      = 8 * BORON_LANES;
    localparam logic [BORON_ROT_W-1:0] BORON_ROT = 32'h09070401;
    localparam int unsigned BORON_STATE_W    = BORON_LANES * BORON_LANE_W;

    // Helpers work on a lane zero-extended to the widest supported lane.
    localparam int unsigned BORON_MAX_LANE_W = 64;
    localparam int unsigned BORON_IDX_W      = $clog2(BORON_MAX_LANE_W);

    typedef logic [BORON_MAX_LANE_W-1:0] lane_t;
    typedef logic [BORON_IDX_W-1:0]      idx_t;

    // Swap the upper and lower halves of a w-bit lane.
    function automatic lane_t lane_sh(input lane_t x, input int unsigned w);
        lane_t r;
        r = '0;
        for (int unsigned j = 0; j < BORON_MAX_LANE_W; j++) begin
            if (j < w) r[idx_t'(j)] = x[idx_t'((j + w / 2) % w)];
        end
        return r;
    endfunction

    function automatic lane_t lane_rotl(input lane_t x, input int unsigned w,
                                        input int unsigned amt);
        lane_t       r;
        int unsigned a;
        r = '0;
        a = amt % w;
        for (int unsigned j = 0; j < BORON_MAX_LANE_W; j++) begin
            if (j < w) r[idx_t'((j + a) % w)] = x[idx_t'(j)];
        end
        return r;
    endfunction

    function automatic lane_t lane_rotr(input lane_t x, input int unsigned w,
                                        input int unsigned amt);
        lane_t       r;
        int unsigned a;
        r = '0;
        a = amt % w;
        for (int unsigned j = 0; j < BORON_MAX_LANE_W; j++) begin
            if (j < w) r[idx_t'(j)] = x[idx_t'((j + a) % w)];
        end
        return r;
    endfunction

endpackage

// File: rtl/permutation_layer_pipe_stage_reg.sv
// Generic {valid, inv, data} pipeline register; load wins over clear, otherwise hold.
module pl_stage_reg
    import boron_pkg::*;
#(
    parameter int unsigned W = BORON_STATE_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic         i_inv,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic         o_inv,
    output logic [W-1:0] o_data
);

    logic         valid_q, valid_d;
    logic         inv_q, inv_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        inv_d   = inv_q;
        data_d  = data_q;
        if (i_load) begin
            valid_d = 1'b1;
            inv_d   = i_inv;
            data_d  = i_data;
        end else if (i_clear) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            inv_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            inv_q   <= inv_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_inv   = inv_q;
    assign o_data  = data_q;

endmodule

// File: rtl/permutation_layer_pipe.sv
// Three-stage pipelined permutation layer (shuffle, rotate, XOR diffusion) with
// per-word inverse mode and valid/ready flow control.
module permutation_layer_pipe
    import boron_pkg::*;
#(
    parameter int unsigned        LANES  = BORON_LANES,
    parameter int unsigned        LANE_W = BORON_LANE_W,
    parameter logic [8*LANES-1:0] ROT    = (8*LANES)'(BORON_ROT)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [LANES*LANE_W-1:0] i_data,
    input  logic                    i_inv,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [LANES*LANE_W-1:0] o_data,
    output logic                    o_inv,
    output logic                    o_busy
);

    localparam int unsigned DATA_W = LANES * LANE_W;

    logic              v1, v2, v3;
    logic              inv1, inv2;
    logic [DATA_W-1:0] d1, d2;
    logic [DATA_W-1:0] op1_c, op2_c, op3_c;
    logic              adv3_c, mv23_c, mv12_c, acc_c;

    // Bubble-collapsing advance chain; ready ripples back combinationally from i_ready.
    assign adv3_c  = v3 & i_ready;
    assign mv23_c  = v2 & (~v3 | adv3_c);
    assign mv12_c  = v1 & (~v2 | mv23_c);
    assign o_ready = ~v1 | mv12_c;
    assign acc_c   = i_valid & o_ready;
    assign o_busy  = v1 | v2 | v3;
    assign o_valid = v3;

    // Stage 1: forward half-swap, or inverse XOR chain resolved from the top lane down.
    always_comb begin : stage1_op
        logic [LANE_W-1:0] chain;
        op1_c = '0;
        chain = '0;
        if (i_inv) begin
            for (int unsigned j = 0; j < LANES; j++) begin
                chain = chain ^ i_data[LANE_W*(LANES-1-j) +: LANE_W];
                op1_c[LANE_W*(LANES-1-j) +: LANE_W] = chain;
            end
        end else begin
            for (int unsigned i = 0; i < LANES; i++) begin
                op1_c[LANE_W*i +: LANE_W] =
                    LANE_W'(lane_sh(lane_t'(i_data[LANE_W*i +: LANE_W]), LANE_W));
            end
        end
    end

    // Stage 2: per-lane rotation, direction chosen by the word's own mode bit.
    always_comb begin : stage2_op
        op2_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (inv1) begin
                op2_c[LANE_W*i +: LANE_W] = LANE_W'(lane_rotr(lane_t'(d1[LANE_W*i +: LANE_W]),
                                                              LANE_W, 32'(ROT[8*i +: 8])));
            end else begin
                op2_c[LANE_W*i +: LANE_W] = LANE_W'(lane_rotl(lane_t'(d1[LANE_W*i +: LANE_W]),
                                                              LANE_W, 32'(ROT[8*i +: 8])));
            end
        end
    end

    // Stage 3: forward XOR with the next lane up (top lane passes), or inverse half-swap.
    always_comb begin : stage3_op
        op3_c = d2 ^ (d2 >> LANE_W);
        if (inv2) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                op3_c[LANE_W*i +: LANE_W] =
                    LANE_W'(lane_sh(lane_t'(d2[LANE_W*i +: LANE_W]), LANE_W));
            end
        end
    end

    pl_stage_reg #(.W(DATA_W)) u_s1 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (acc_c),
        .i_clear (mv12_c),
        .i_inv   (i_inv),
        .i_data  (op1_c),
        .o_valid (v1),
        .o_inv   (inv1),
        .o_data  (d1)
    );

    pl_stage_reg #(.W(DATA_W)) u_s2 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (mv12_c),
        .i_clear (mv23_c),
        .i_inv   (inv1),
        .i_data  (op2_c),
        .o_valid (v2),
        .o_inv   (inv2),
        .o_data  (d2)
    );

    pl_stage_reg #(.W(DATA_W)) u_s3 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (mv23_c),
        .i_clear (adv3_c),
        .i_inv   (inv2),
        .i_data  (op3_c),
        .o_valid (v3),
        .o_inv   (o_inv),
        .o_data  (o_data)
    );

endmodule
